flash_audio_sequencer: RTL and testbench
========================================

# flash_audio_sequencer

Sequences 32-bit Avalon-MM flash reads for song playback under keyboard control. Holds the word address and play direction, and issues one read per two samples. It splits each word into two 8-bit samples and emits one sample per synchronized sample tick. It sits between the PS/2 key decoder and the flash controller, and feeds the audio output path.

## Interface
- LAST_ADDR, 23'h7FFFF, last valid word address of the song region
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- sample_tick  in  1  one-cycle pulse, already synchronized to clk (sample rate)
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  8  ASCII key
- flash_mem_read  out  1  Avalon read request
- flash_mem_address  out  23  word address
- flash_mem_byteenable  out  4  constant 4'hF
- flash_mem_waitrequest  in  1  slave stall
- flash_mem_readdata  in  32  read data
- flash_mem_readdatavalid  in  1  read data strobe
- audio_data  out  8  current sample (bits [15:8] of selected half-word)
- audio_valid  out  1  one-cycle pulse when audio_data updates
- playing  out  1  play state
- dir_backward  out  1  0 = forward, 1 = backward

## Operation
- Keys are case-insensitive:
  - E/e (8'h45/8'h65) sets playing.
  - D/d (8'h44/8'h64) clears playing.
  - F/f (8'h46/8'h66) clears dir_backward.
  - B/b (8'h42/8'h62) sets dir_backward.
  - R/r (8'h52/8'h72) requests a restart.
  - Any other code is ignored.
- Restart sets the address to 0 when forward, or LAST_ADDR when backward. It discards any latched second sample. Restart does not change playing.
- States:
  - IDLE: not playing.
  - WAIT_TICK: playing, no word buffered.
  - READ_REQ: flash_mem_read=1.
  - WAIT_DATA: awaiting readdatavalid.
  - EMIT_FIRST: emit the first sample.
  - WAIT_TICK2: emit the second sample on tick.
- Transitions:
  - IDLE→WAIT_TICK when playing.
  - WAIT_TICK→READ_REQ on sample_tick.
  - READ_REQ→WAIT_DATA when waitrequest=0.
  - WAIT_DATA→EMIT_FIRST on readdatavalid; the word is latched.
  - EMIT_FIRST→WAIT_TICK2.
  - WAIT_TICK2→WAIT_TICK on sample_tick: emit the second sample, then advance the address.
- Sample order:
  - Forward: readdata[15:0], then [31:16].
  - Backward: [31:16], then [15:0].
  - Direction is sampled at EMIT_FIRST.
- Address advance: forward +1, backward −1.
  - Wrap-around: LAST_ADDR→0 (forward) and 0→LAST_ADDR (backward).
- Stop during READ_REQ or WAIT_DATA: the read completes (request held until accepted, data consumed). Nothing is emitted. The FSM then goes to IDLE with the address unchanged, so the word is re-read on resume.
- Stop in WAIT_TICK or WAIT_TICK2 → IDLE. The buffered second sample is discarded and the address is not advanced.
- Restart during an outstanding read: the request is latched and applied once readdatavalid arrives. The fetched word is discarded and the FSM goes to WAIT_TICK.
- Same-cycle key_valid and sample_tick: the key is applied first. If it stops or restarts, the tick is ignored.
- Direction keys never abort a transaction. A direction change takes effect at the next EMIT_FIRST and address advance.

## Timing
- Reset values:
  - flash_mem_read=0, flash_mem_address=0, audio_data=8'h00, audio_valid=0, playing=0, dir_backward=0, state=IDLE.
  - Reset mid-transaction drops the read immediately.
- flash_mem_read and flash_mem_address are registered. They are held stable while waitrequest=1.
- A single outstanding read at most. flash_mem_read deasserts the cycle after acceptance.
- First sample latency: readdatavalid at edge N → audio_valid and audio_data at edge N+1.
- Second sample: audio_valid one cycle after the qualifying sample_tick.
- audio_data holds between pulses.
- Key effect: outputs update on the edge after key_valid.

## Configuration
- FLASH_AUDIO_LOOP_EN defined: wrap-around as above; playback loops indefinitely.
- Not defined: after emitting the last sample of LAST_ADDR (forward) or address 0 (backward):
  - playing clears and the FSM goes to IDLE.
  - The address is reset to the start for the current direction.

## Structure
- Package flash_audio_pkg holds:
  - the state enum;
  - the key code constants (upper and lower case);
  - the 23-bit address width constant.
- Sub-module flash_audio_key_decode: combinational key_code/key_valid → play, stop, fwd, bwd, restart one-hot strobes.

## Test plan
- Reset, then key 8'h65 and tick with zero-wait flash returning 32'hAABB_CCDD:
  - read at address 0;
  - audio_data=8'hCC, then 8'hAA on the next tick;
  - address becomes 1.
- Key 8'h42 then 8'h72 (backward, restart) while playing:
  - next read at LAST_ADDR;
  - for word 32'h1122_3344, emits 8'h11 then 8'h33.
- waitrequest held high 5 cycles during READ_REQ: read and address are stable for all 5 cycles and deassert the cycle after acceptance.
- Key 8'h44 during WAIT_DATA:
  - no audio_valid; IDLE;
  - after 8'h65 and a tick, the same address is re-read.
- Forward play through LAST_ADDR:
  - with FLASH_AUDIO_LOOP_EN, the next read is at 0;
  - without it, playing=0 and the address is 0.
- Same-cycle key 8'h64 and sample_tick in WAIT_TICK: no read is issued and playing=0.

Source files
------------

// File: rtl/flash_audio_pkg.sv
// flash_audio_pkg: shared types and constants for the flash audio sequencer.
// Holds the FSM state enum, ASCII key codes and the word address width.
package flash_audio_pkg;

  localparam int ADDR_W = 23;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_TICK  = 3'd1,
    ST_READ_REQ   = 3'd2,
    ST_WAIT_DATA  = 3'd3,
    ST_EMIT_FIRST = 3'd4,
    ST_WAIT_TICK2 = 3'd5
  } state_e;

  localparam logic [7:0] KEY_E_UC = 8'h45;
  localparam logic [7:0] KEY_E_LC = 8'h65;
  localparam logic [7:0] KEY_D_UC = 8'h44;
  localparam logic [7:0] KEY_D_LC = 8'h64;
  localparam logic [7:0] KEY_F_UC = 8'h46;
  localparam logic [7:0] KEY_F_LC = 8'h66;
  localparam logic [7:0] KEY_B_UC = 8'h42;
  localparam logic [7:0] KEY_B_LC = 8'h62;
  localparam logic [7:0] KEY_R_UC = 8'h52;
  localparam logic [7:0] KEY_R_LC = 8'h72;

endpackage

// File: rtl/flash_audio_key_decode.sv
// flash_audio_key_decode: maps a key strobe to one-hot command strobes.
// Ports: i_key_valid/i_key_code in; o_play/o_stop/o_fwd/o_bwd/o_restart out.
module flash_audio_key_decode
  import flash_audio_pkg::*;
(
  input  logic       i_key_valid,
  input  logic [7:0] i_key_code,
  output logic       o_play,
  output logic       o_stop,
  output logic       o_fwd,
  output logic       o_bwd,
  output logic       o_restart
);

  function automatic logic is_key(
    input logic [7:0] c,
    input logic [7:0] uc,
    input logic [7:0] lc
  );
    return (c == uc) || (c == lc);
  endfunction

  assign o_play    = i_key_valid &
                     is_key(i_key_code, KEY_E_UC, KEY_E_LC);
  assign o_stop    = i_key_valid &
                     is_key(i_key_code, KEY_D_UC, KEY_D_LC);
  assign o_fwd     = i_key_valid &
                     is_key(i_key_code, KEY_F_UC, KEY_F_LC);
  assign o_bwd     = i_key_valid &
                     is_key(i_key_code, KEY_B_UC, KEY_B_LC);
  assign o_restart = i_key_valid &
                     is_key(i_key_code, KEY_R_UC, KEY_R_LC);

endmodule

// File: rtl/flash_audio_sequencer.sv
// flash_audio_sequencer: keyboard-controlled flash reader, two 8-bit samples
// per 32-bit word, one sample per tick. Macro FLASH_AUDIO_LOOP_EN: loop song.
module flash_audio_sequencer
  import flash_audio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [7:0]        audio_data,
  output logic              audio_valid,
  output logic              playing,
  output logic              dir_backward
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_read;
  logic              r_playing;
  logic              r_dir;
  logic              r_rst_pend;
  logic [7:0]        r_b1;
  logic [7:0]        r_b3;
  logic [7:0]        r_second;
  logic [7:0]        r_audio;
  logic              r_valid;

  logic              w_play;
  logic              w_stop;
  logic              w_fwd;
  logic              w_bwd;
  logic              w_restart;
  logic              w_playing_n;
  logic              w_dir_n;
  logic [ADDR_W-1:0] w_start;
  logic              w_at_end;
  logic [ADDR_W-1:0] w_addr_adv;

  flash_audio_key_decode u_key (
    .i_key_valid (key_valid),
    .i_key_code  (key_code),
    .o_play      (w_play),
    .o_stop      (w_stop),
    .o_fwd       (w_fwd),
    .o_bwd       (w_bwd),
    .o_restart   (w_restart)
  );

  // Key effects are resolved first so a same-cycle tick sees them.
  assign w_playing_n = w_stop ? 1'b0 : (w_play ? 1'b1 : r_playing);
  assign w_dir_n     = w_bwd ? 1'b1 : (w_fwd ? 1'b0 : r_dir);

  assign w_start  = r_dir ? LAST_ADDR : '0;
  assign w_at_end = r_dir ? (r_addr == '0) : (r_addr == LAST_ADDR);

  // The wrap target equals the start address of the current direction,
  // so the non-looping build reuses it when the song ends.
  assign w_addr_adv = w_at_end ? (r_dir ? LAST_ADDR : '0) :
                      r_dir    ? r_addr - ADDR_W'(1) :
                                 r_addr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_playing  <= 1'b0;
      r_dir      <= 1'b0;
      r_rst_pend <= 1'b0;
      r_b1       <= 8'h00;
      r_b3       <= 8'h00;
      r_second   <= 8'h00;
      r_audio    <= 8'h00;
      r_valid    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_playing <= w_playing_n;
      r_dir     <= w_dir_n;
      unique case (r_state)
        ST_IDLE: begin
          if (w_restart) r_addr <= w_start;
          if (w_playing_n) r_state <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (w_restart) r_addr <= w_start;
          if (!w_playing_n) begin
            r_state <= ST_IDLE;
          end else if (!w_restart && sample_tick) begin
            r_read  <= 1'b1;
            r_state <= ST_READ_REQ;
          end
        end
        ST_READ_REQ: begin
          if (w_restart) r_rst_pend <= 1'b1;
          if (!flash_mem_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (flash_mem_readdatavalid) begin
            r_rst_pend <= 1'b0;
            if (r_rst_pend || w_restart) begin
              r_addr  <= w_start;
              r_state <= w_playing_n ? ST_WAIT_TICK : ST_IDLE;
            end else if (!w_playing_n) begin
              r_state <= ST_IDLE;
            end else begin
              r_b1    <= flash_mem_readdata[15:8];
              r_b3    <= flash_mem_readdata[31:24];
              r_state <= ST_EMIT_FIRST;
            end
          end else if (w_restart) begin
            r_rst_pend <= 1'b1;
          end
        end
        ST_EMIT_FIRST: begin
          if (w_restart) r_addr <= w_start;
          if (!w_playing_n) begin
            r_state <= ST_IDLE;
          end else if (w_restart) begin
            r_state <= ST_WAIT_TICK;
          end else begin
            r_audio  <= r_dir ? r_b3 : r_b1;
            r_second <= r_dir ? r_b1 : r_b3;
            r_valid  <= 1'b1;
            r_state  <= ST_WAIT_TICK2;
          end
        end
        ST_WAIT_TICK2: begin
          if (w_restart) r_addr <= w_start;
          if (!w_playing_n) begin
            r_state <= ST_IDLE;
          end else if (w_restart) begin
            r_state <= ST_WAIT_TICK;
          end else if (sample_tick) begin
            r_audio <= r_second;
            r_valid <= 1'b1;
            r_addr  <= w_addr_adv;
`ifdef FLASH_AUDIO_LOOP_EN
            r_state <= ST_WAIT_TICK;
`else
            if (w_at_end) begin
              r_playing <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_TICK;
            end
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign flash_mem_read       = r_read;
  assign flash_mem_address    = r_addr;
  assign flash_mem_byteenable = 4'hF;
  assign audio_data           = r_audio;
  assign audio_valid          = r_valid;
  assign playing              = r_playing;
  assign dir_backward         = r_dir;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// tb_flash_audio_sequencer: scoreboard bench with a small Avalon flash slave.
// Expected read addresses and samples are queued as stimulus is set up.
module tb_flash_audio_sequencer;

  localparam logic [22:0] LAST = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        waitreq = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        rdv = 1'b0;
  logic [7:0]  audio_data;
  logic        audio_valid;
  logic        playing;
  logic        dir_backward;

  always #5 clk = ~clk;

  flash_audio_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .sample_tick             (sample_tick),
    .key_valid               (key_valid),
    .key_code                (key_code),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (waitreq),
    .flash_mem_readdata      (rdata),
    .flash_mem_readdatavalid (rdv),
    .audio_data              (audio_data),
    .audio_valid             (audio_valid),
    .playing                 (playing),
    .dir_backward            (dir_backward)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_audio = 0;
  int n_stall = 0;
  int stall_left = 0;
  int rdv_delay = 0;
  int data_cnt = 0;
  logic prev_acc = 1'b0;
  logic [31:0] flash_word = 32'h0;
  logic [7:0]  exp_audio[$];
  logic [22:0] exp_addr[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Flash slave: optional waitrequest stall, data after rdv_delay cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdv = 1'b0;
      if (data_cnt > 0) begin
        data_cnt--;
        if (data_cnt == 0) begin
          rdv   = 1'b1;
          rdata = flash_word;
        end
      end
      if (flash_mem_read && stall_left > 0) begin
        waitreq = 1'b1;
        stall_left--;
      end else begin
        waitreq = 1'b0;
      end
    end
  end

  // Monitor and scoreboard comparisons.
  always @(negedge clk) begin
    logic acc;
    acc = 1'b0;
    if (!reset) begin
      if (audio_valid) begin
        n_audio++;
        if (exp_audio.size() == 0)
          chk("audio_unexp", {24'h0, audio_data}, 32'hFFFF_FFFF);
        else
          chk("audio", {24'h0, audio_data}, {24'h0, exp_audio.pop_front()});
      end
      if (prev_acc) chk("rd_drop", {31'h0, flash_mem_read}, 32'h0);
      if (flash_mem_read && waitreq) begin
        n_stall++;
        if (exp_addr.size() > 0)
          chk("stall_addr", {9'h0, flash_mem_address}, {9'h0, exp_addr[0]});
      end
      if (flash_mem_read && !waitreq) begin
        acc = 1'b1;
        data_cnt = 1 + rdv_delay;
        if (exp_addr.size() == 0)
          chk("rd_unexp", {9'h0, flash_mem_address}, 32'hFFFF_FFFF);
        else
          chk("rd_addr", {9'h0, flash_mem_address}, {9'h0, exp_addr.pop_front()});
      end
    end
    prev_acc = acc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pkey(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    step();
    key_valid = 1'b0;
  endtask

  task automatic ptick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic wait_audio(input int target);
    for (int i = 0; i < 60; i++) begin
      if (n_audio >= target) break;
      step();
    end
    chk("audio_wait", {31'h0, n_audio >= target}, 32'h1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_read", {31'h0, flash_mem_read}, 32'h0);
    chk("rst_addr", {9'h0, flash_mem_address}, 32'h0);
    chk("rst_audio", {24'h0, audio_data}, 32'h0);
    chk("rst_valid", {31'h0, audio_valid}, 32'h0);
    chk("rst_play", {31'h0, playing}, 32'h0);
    chk("rst_dir", {31'h0, dir_backward}, 32'h0);
    chk("byteen", {28'h0, flash_mem_byteenable}, 32'hF);
    reset = 1'b0;
    step();

    // Forward play of one word.
    flash_word = 32'hAABB_CCDD;
    exp_addr.push_back(23'd0);
    exp_audio.push_back(8'hCC);
    exp_audio.push_back(8'hAA);
    pkey(8'h65);
    chk("play_on", {31'h0, playing}, 32'h1);
    ptick();
    wait_audio(1);
    ptick();
    wait_audio(2);
    chk("addr_fwd", {9'h0, flash_mem_address}, 32'd1);

    // Backward, restart.
    pkey(8'h42);
    chk("dir_bwd", {31'h0, dir_backward}, 32'h1);
    pkey(8'h72);
    chk("addr_rst", {9'h0, flash_mem_address}, {9'h0, LAST});
    flash_word = 32'h1122_3344;
    exp_addr.push_back(LAST);
    exp_audio.push_back(8'h11);
    exp_audio.push_back(8'h33);
    ptick();
    wait_audio(3);
    ptick();
    wait_audio(4);
    chk("addr_bwd", {9'h0, flash_mem_address}, {9'h0, LAST - 23'd1});

    // Waitrequest stall of 5 cycles.
    n_stall = 0;
    stall_left = 5;
    flash_word = 32'h5566_7788;
    exp_addr.push_back(LAST - 23'd1);
    exp_audio.push_back(8'h55);
    exp_audio.push_back(8'h77);
    ptick();
    wait_audio(5);
    chk("stall_cnt", n_stall, 32'd5);
    ptick();
    wait_audio(6);

    // Stop during WAIT_DATA, then resume re-reads same word.
    rdv_delay = 4;
    flash_word = 32'hDEAD_BEEF;
    exp_addr.push_back(LAST - 23'd2);
    ptick();
    step();
    pkey(8'h64);
    chk("stop_play", {31'h0, playing}, 32'h0);
    repeat (10) step();
    chk("stop_noaud", n_audio, 32'd6);
    chk("stop_addr", {9'h0, flash_mem_address}, {9'h0, LAST - 23'd2});
    rdv_delay = 0;
    flash_word = 32'h99AA_BBCC;
    exp_addr.push_back(LAST - 23'd2);
    exp_audio.push_back(8'h99);
    exp_audio.push_back(8'hBB);
    pkey(8'h45);
    ptick();
    wait_audio(7);
    ptick();
    wait_audio(8);

    // Forward through LAST.
    pkey(8'h72);
    pkey(8'h46);
    chk("dir_fwd", {31'h0, dir_backward}, 32'h0);
    chk("addr_last", {9'h0, flash_mem_address}, {9'h0, LAST});
    flash_word = 32'h0102_0304;
    exp_addr.push_back(LAST);
    exp_audio.push_back(8'h03);
    exp_audio.push_back(8'h01);
    ptick();
    wait_audio(9);
    ptick();
    wait_audio(10);
    chk("end_addr", {9'h0, flash_mem_address}, 32'h0);
`ifdef FLASH_AUDIO_LOOP_EN
    chk("end_play", {31'h0, playing}, 32'h1);
    flash_word = 32'h0F0E_0D0C;
    exp_addr.push_back(23'd0);
    exp_audio.push_back(8'h0D);
    exp_audio.push_back(8'h0F);
    ptick();
    wait_audio(11);
    ptick();
    wait_audio(12);
`else
    chk("end_play", {31'h0, playing}, 32'h0);
    ptick();
    repeat (5) step();
    pkey(8'h65);
`endif

    // Same-cycle stop and tick in WAIT_TICK.
    begin
      int na;
      na = n_audio;
      key_valid   = 1'b1;
      key_code    = 8'h64;
      sample_tick = 1'b1;
      step();
      key_valid   = 1'b0;
      sample_tick = 1'b0;
      repeat (6) step();
      chk("same_play", {31'h0, playing}, 32'h0);
      chk("same_read", {31'h0, flash_mem_read}, 32'h0);
      chk("same_noaud", n_audio, na);
    end

    chk("exp_audio_left", exp_audio.size(), 32'd0);
    chk("exp_addr_left", exp_addr.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
